// File: rtl/inst_fetch_pkg.sv
// inst_fetch_pkg: shared constants, FSM states and queue entry type for the fetch unit
//   RESET_PC default, fetch-queue depth default, read opcode, state encoding,
//   {pc, instr} queue entry, word-alignment helper.
package inst_fetch_pkg;
   localparam logic [31:0] INST_CACHE_OFFSET   = 32'h0000_0000;
   localparam logic [31:0] INST_FETCH_RESET_PC = INST_CACHE_OFFSET;
   localparam int          FQ_DEPTH_DEFAULT    = 4;
   localparam logic        MEM_OP_READ         = 1'b0;

   typedef enum logic [1:0] {
      S_REQ_OFF = 2'd0,
      S_REQ     = 2'd1,
      S_DROP    = 2'd2
   } state_e;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fq_entry_t;

   function automatic logic [31:0] word_align(input logic [31:0] a);
      return {a[31:2], 2'b00};
   endfunction
endpackage

// File: rtl/inst_fetch_if.sv
// inst_fetch_if: request/acknowledge read bus between inst_fetch and inst_cache
//   mem_req/mem_addr/mem_op_type : fetch -> cache
//   mem_ack/mem_rdata            : cache -> fetch
interface inst_fetch_if;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_op_type;
   logic        mem_ack;
   logic [31:0] mem_rdata;

   modport master (output mem_req, mem_addr, mem_op_type, input mem_ack, mem_rdata);
   modport slave  (input mem_req, mem_addr, mem_op_type, output mem_ack, mem_rdata);
endinterface

// File: rtl/inst_fetch_fetch_queue.sv
// fetch_queue: circular FIFO of {pc, instr} entries between fetch and decode
//   clk, rst (async, active-low)
//   push/din    : enqueue (dropped if full unless a pop frees a slot)
//   pop         : dequeue head (ignored when empty)
//   flush       : empty the queue, wins over push and pop
//   head        : current head entry, zero when empty
//   full, empty, count
module fetch_queue
   import inst_fetch_pkg::*;
#(
   parameter  int DEPTH = FQ_DEPTH_DEFAULT,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        push,
   input  logic        pop,
   input  logic        flush,
   input  fq_entry_t   din,
   output fq_entry_t   head,
   output logic        full,
   output logic        empty,
   output logic [AW:0] count
);
   fq_entry_t     mem_q [DEPTH];
   logic [AW-1:0] head_q, head_d, tail_q, tail_d;
   logic [AW:0]   count_q, count_d;
   logic          do_push, do_pop;

   always_comb begin
      do_pop  = pop && !empty;
      do_push = push && (!full || do_pop);
      head_d  = flush ? '0 : head_q + AW'(do_pop);
      tail_d  = flush ? '0 : tail_q + AW'(do_push);
      count_d = flush ? '0 : count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !flush) mem_q[tail_q] <= din;
   end

   assign empty = count_q == '0;
   assign full  = count_q == (AW+1)'(DEPTH);
   assign count = count_q;
   assign head  = empty ? '0 : mem_q[head_q];
endmodule

// File: rtl/inst_fetch.sv
// inst_fetch: PC holder and sequential instruction-cache read initiator with fetch queue
//   clk, rst (async, active-low)
//   mem (master)            : request/ack read bus to inst_cache
//   redirect, redirect_pc   : flush and restart fetch at redirect_pc (word aligned)
//   fq_valid/fq_instr/fq_pc : queue head to decode, consumed when fq_ready
module inst_fetch
   import inst_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = INST_FETCH_RESET_PC,
   parameter int          FQ_DEPTH = FQ_DEPTH_DEFAULT
) (
   input  logic          clk,
   input  logic          rst,
   inst_fetch_if.master  mem,
   input  logic          redirect,
   input  logic [31:0]   redirect_pc,
   output logic          fq_valid,
   output logic [31:0]   fq_instr,
   output logic [31:0]   fq_pc,
   input  logic          fq_ready
);
   localparam int AW = $clog2(FQ_DEPTH);

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d, addr_q, addr_d;
   logic [31:0] target;
   logic [AW:0] count;
   logic        full, empty, push, pop, space;
   fq_entry_t   head;

   assign target = word_align(redirect_pc);
   assign push   = state_q == S_REQ && mem.mem_ack && !redirect;
   assign pop    = fq_valid && fq_ready;
   // count + push - pop < FQ_DEPTH. A full queue implies no request is
   // outstanding (so no push), and only a pop can make room.
   assign space  = full ? pop : !(push && !pop && count == (AW+1)'(FQ_DEPTH - 1));

   fetch_queue #(.DEPTH(FQ_DEPTH)) u_fq (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .flush (redirect),
      .din   ({addr_q, mem.mem_rdata}),
      .head  (head),
      .full  (full),
      .empty (empty),
      .count (count)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_REQ_OFF;
         pc_q    <= RESET_PC;
         addr_q  <= RESET_PC;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         addr_q  <= addr_d;
      end
   end

   // addr_q is the address on the bus and must not move while a request
   // waits for ack; pc_q carries the next fetch address or a pending target.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      addr_d  = addr_q;
      case (state_q)
         S_REQ_OFF: begin
            if (redirect || space) begin
               state_d = S_REQ;
               pc_d    = redirect ? target : pc_q;
               addr_d  = pc_d;
            end
         end
         S_REQ: begin
            if (mem.mem_ack) begin
               pc_d    = redirect ? target : pc_q + 32'd4;
               addr_d  = pc_d;
               state_d = (redirect || space) ? S_REQ : S_REQ_OFF;
            end else if (redirect) begin
               pc_d    = target;
               state_d = S_DROP;
            end
         end
         S_DROP: begin
            pc_d = redirect ? target : pc_q;
            if (mem.mem_ack) begin
               state_d = S_REQ;
               addr_d  = pc_d;
            end
         end
         default: state_d = S_REQ_OFF;
      endcase
   end

   always_comb begin
      mem.mem_req     = state_q != S_REQ_OFF;
      mem.mem_addr    = addr_q;
      mem.mem_op_type = MEM_OP_READ;
      fq_valid        = !empty;
      fq_pc           = head.pc;
      fq_instr        = head.instr;
   end
endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: directed vector table, reset sequences and random run against a queue model
module tb_inst_fetch;
   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        ack = 1'b0;
   logic [31:0] rdata = '0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        fq_ready = 1'b0;
   logic        fq_valid;
   logic [31:0] fq_instr, fq_pc;

   always #5 clk = ~clk;

   inst_fetch_if bus ();
   assign bus.mem_ack   = ack;
   assign bus.mem_rdata = rdata;

   inst_fetch #(.RESET_PC(32'h0), .FQ_DEPTH(DEPTH)) dut (
      .clk         (clk),
      .rst         (rst),
      .mem         (bus.master),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .fq_valid    (fq_valid),
      .fq_instr    (fq_instr),
      .fq_pc       (fq_pc),
      .fq_ready    (fq_ready)
   );

   int total = 0;
   int bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   typedef struct {
      logic        ack, rd;
      logic [31:0] rpc;
      logic        rdy;
      logic [31:0] rdata;
      logic        ereq;
      logic [31:0] eaddr;
      logic        evalid;
      logic [31:0] epc, einstr;
   } vec_t;

   vec_t vq[$];

   task automatic add(input logic a, input logic r, input logic [31:0] rp, input logic y,
                      input logic [31:0] d, input logic eq, input logic [31:0] ea,
                      input logic ev, input logic [31:0] ep, input logic [31:0] ei);
      vec_t t;
      t.ack = a; t.rd = r; t.rpc = rp; t.rdy = y; t.rdata = d;
      t.ereq = eq; t.eaddr = ea; t.evalid = ev; t.epc = ep; t.einstr = ei;
      vq.push_back(t);
   endtask

   // Reference model: a queue of fetched words plus the outstanding request.
   typedef struct packed { logic [31:0] pc; logic [31:0] instr; } ent_t;
   ent_t        m_q[$];
   bit          m_req, m_drop;
   logic [31:0] m_addr, m_pc;

   task automatic model_reset();
      m_q.delete();
      m_req = 0; m_drop = 0; m_addr = '0; m_pc = '0;
   endtask

   task automatic model_edge(input logic a, input logic r, input logic [31:0] rp,
                             input logic y, input logic [31:0] d);
      bit          done;
      logic [31:0] tgt;
      ent_t        e;
      done = m_req && a;
      tgt  = rp & 32'hFFFF_FFFC;
      if (r) m_q.delete();
      else begin
         if (y && m_q.size() > 0) void'(m_q.pop_front());
         if (done && !m_drop) begin
            e.pc = m_addr; e.instr = d;
            m_q.push_back(e);
         end
      end
      if (done && !m_drop && !r) m_pc = m_addr + 32'd4;
      if (r) m_pc = tgt;
      if (m_req && !a) begin
         if (r) m_drop = 1;
      end else begin
         m_drop = 0;
         m_req  = r || m_q.size() < DEPTH;
         if (m_req) m_addr = m_pc;
      end
   endtask

   initial begin
      // zero-wait streaming
      add(0,0,0,1,0,                      1,32'h0,       0,0,0);
      add(1,0,0,1,32'hA0,                 1,32'h4,       1,32'h0,32'hA0);
      add(1,0,0,1,32'hA1,                 1,32'h8,       1,32'h4,32'hA1);
      add(1,0,0,1,32'hA2,                 1,32'hC,       1,32'h8,32'hA2);
      // drain, then wait states on 0xC
      add(0,0,0,1,0,                      1,32'hC,       0,0,0);
      add(0,0,0,0,0,                      1,32'hC,       0,0,0);
      add(0,0,0,0,0,                      1,32'hC,       0,0,0);
      // backpressure: four acks fill the queue
      add(1,0,0,0,32'hB0,                 1,32'h10,      1,32'hC,32'hB0);
      add(1,0,0,0,32'hB1,                 1,32'h14,      1,32'hC,32'hB0);
      add(1,0,0,0,32'hB2,                 1,32'h18,      1,32'hC,32'hB0);
      add(1,0,0,0,32'hB3,                 0,0,           1,32'hC,32'hB0);
      add(1,0,0,0,32'hEE,                 0,0,           1,32'hC,32'hB0);
      // one pop -> exactly one new request
      add(0,0,0,1,0,                      1,32'h1C,      1,32'h10,32'hB1);
      add(1,0,0,0,32'hB4,                 0,0,           1,32'h10,32'hB1);
      add(0,0,0,0,0,                      0,0,           1,32'h10,32'hB1);
      add(0,0,0,1,0,                      1,32'h20,      1,32'h14,32'hB2);
      add(0,0,0,1,0,                      1,32'h20,      1,32'h18,32'hB3);
      add(0,0,0,1,0,                      1,32'h20,      1,32'h1C,32'hB4);
      add(0,0,0,1,0,                      1,32'h20,      0,0,0);
      // redirect without ack: 0x20 held, its data dropped
      add(0,1,32'h100,1,0,                1,32'h20,      0,0,0);
      add(0,0,0,1,0,                      1,32'h20,      0,0,0);
      add(1,0,0,1,32'hDEAD,               1,32'h100,     0,0,0);
      add(1,0,0,0,32'hC0,                 1,32'h104,     1,32'h100,32'hC0);
      add(1,0,0,1,32'hC1,                 1,32'h108,     1,32'h104,32'hC1);
      // redirect with ack and pop, unaligned target
      add(1,1,32'h203,1,32'hBAD,          1,32'h200,     0,0,0);
      add(1,0,0,1,32'hD0,                 1,32'h204,     1,32'h200,32'hD0);
      // PC wrap at top of address space
      add(0,1,32'hFFFF_FFFD,1,0,          1,32'h204,     0,0,0);
      add(1,0,0,1,32'hBAD,                1,32'hFFFF_FFFC,0,0,0);
      add(1,0,0,0,32'hE0,                 1,32'h0,       1,32'hFFFF_FFFC,32'hE0);
      add(1,0,0,1,32'hE1,                 1,32'h4,       1,32'h0,32'hE1);
      // redirect overwrite in drop, then redirect + ack in drop
      add(0,1,32'h300,1,0,                1,32'h4,       0,0,0);
      add(0,1,32'h400,1,0,                1,32'h4,       0,0,0);
      add(1,0,0,1,32'hBAD,                1,32'h400,     0,0,0);
      add(0,1,32'h500,1,0,                1,32'h400,     0,0,0);
      add(1,1,32'h600,1,32'hBAD,          1,32'h600,     0,0,0);
      add(1,0,0,1,32'hF0,                 1,32'h604,     1,32'h600,32'hF0);

      repeat (2) @(posedge clk);
      #1;
      chk("rst_req", 32'(bus.mem_req), 32'h0);
      chk("rst_addr", bus.mem_addr, 32'h0);
      chk("rst_op", 32'(bus.mem_op_type), 32'h0);
      chk("rst_valid", 32'(fq_valid), 32'h0);
      chk("rst_pc", fq_pc, 32'h0);
      chk("rst_instr", fq_instr, 32'h0);
      rst = 1'b1;

      foreach (vq[i]) begin
         ack = vq[i].ack; redirect = vq[i].rd; redirect_pc = vq[i].rpc;
         fq_ready = vq[i].rdy; rdata = vq[i].rdata;
         @(posedge clk);
         #1;
         chk($sformatf("v%0d_req", i), 32'(bus.mem_req), 32'(vq[i].ereq));
         if (vq[i].ereq) chk($sformatf("v%0d_addr", i), bus.mem_addr, vq[i].eaddr);
         chk($sformatf("v%0d_valid", i), 32'(fq_valid), 32'(vq[i].evalid));
         chk($sformatf("v%0d_pc", i), fq_pc, vq[i].epc);
         chk($sformatf("v%0d_instr", i), fq_instr, vq[i].einstr);
         chk($sformatf("v%0d_op", i), 32'(bus.mem_op_type), 32'h0);
      end

      // async reset while a request waits and the queue holds an entry
      ack = 0; redirect = 0; fq_ready = 0;
      @(posedge clk);
      #1;
      chk("pre_arst_valid", 32'(fq_valid), 32'h1);
      #2 rst = 1'b0;
      #1;
      chk("arst_req", 32'(bus.mem_req), 32'h0);
      chk("arst_valid", 32'(fq_valid), 32'h0);
      chk("arst_addr", bus.mem_addr, 32'h0);
      chk("arst_pc", fq_pc, 32'h0);
      @(posedge clk);
      #1 rst = 1'b1;
      ack = 1'b1; rdata = 32'h5555;
      @(posedge clk);
      #1;
      chk("rel_req", 32'(bus.mem_req), 32'h1);
      chk("rel_addr", bus.mem_addr, 32'h0);
      chk("rel_valid", 32'(fq_valid), 32'h0);
      rdata = 32'h1234;
      @(posedge clk);
      #1;
      chk("rel_fq_valid", 32'(fq_valid), 32'h1);
      chk("rel_fq_pc", fq_pc, 32'h0);
      chk("rel_fq_instr", fq_instr, 32'h1234);
      chk("rel_addr2", bus.mem_addr, 32'h4);

      // randomized run against the model
      ack = 0;
      rst = 1'b0;
      @(posedge clk);
      #1 rst = 1'b1;
      model_reset();
      for (int n = 0; n < 3000; n++) begin
         ack         = ($urandom_range(0, 9) < 6);
         redirect    = ($urandom_range(0, 99) < 8);
         redirect_pc = $urandom;
         fq_ready    = ($urandom_range(0, 9) < 5);
         rdata       = $urandom;
         @(posedge clk);
         model_edge(ack, redirect, redirect_pc, fq_ready, rdata);
         #1;
         chk("rnd_req", 32'(bus.mem_req), 32'(m_req));
         if (m_req) chk("rnd_addr", bus.mem_addr, m_addr);
         chk("rnd_valid", 32'(fq_valid), 32'(m_q.size() > 0));
         chk("rnd_pc", fq_pc, m_q.size() > 0 ? m_q[0].pc : 32'h0);
         chk("rnd_instr", fq_instr, m_q.size() > 0 ? m_q[0].instr : 32'h0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
- Initiator side of the instruction-cache read interface.
- Holds the PC and issues sequential word-read requests to inst_cache through a request/acknowledge handshake.
- Buffers returned instructions, tagged with their PC, in a small fetch queue that drains to decode via valid/ready.
- Supports redirects from branch/jump resolution, which flush the queue and discard any in-flight response.

Parameters:
- RESET_PC, `_INST_CACHE_OFFSET, first fetch address after reset (bits [1:0] must be 0).
- FQ_DEPTH, 4, fetch-queue entries (power of two, >=2).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-low.
- mem_req  output  1  read request to cache.
- mem_addr  output  32  byte address of requested word.
- mem_op_type  output  1  constant 0 (read); 1 is never driven.
- mem_ack  input  1  cache accepts the request; mem_rdata valid this cycle.
- mem_rdata  input  32  instruction word, little-endian as assembled by cache.
- redirect  input  1  flush and restart fetch.
- redirect_pc  input  32  new fetch address; bits [1:0] ignored (treated as 0).
- fq_valid  output  1  queue head valid.
- fq_instr  output  32  queue head instruction.
- fq_pc  output  32  queue head PC.
- fq_ready  input  1  decode consumes head when fq_valid and fq_ready.

Behaviour:
- Reset (rst=0, async):
  - mem_req=0, mem_addr=RESET_PC, pc=RESET_PC, queue empty, fq_valid=0, fq_instr=0, fq_pc=0, state=S_REQ_OFF.
  - Assertion mid-transaction abandons everything immediately; no response is later accepted.
- First rising edge after rst=1: state S_REQ, mem_req=1, mem_addr=RESET_PC.
- Handshake rules:
  - While mem_req=1 and mem_ack=0, mem_addr must stay stable and mem_req must stay 1 (no withdrawal, including on redirect).
  - Transfer completes on an edge where mem_req=1 and mem_ack=1; mem_rdata is sampled on that edge.
- States:
  - S_REQ_OFF: no request. Enter S_REQ when space is available or a redirect arrives.
  - S_REQ: request outstanding.
    - ack, no redirect: push {pc, mem_rdata}; pc<=pc+4. If space remains, stay in S_REQ with mem_addr=pc+4 (back-to-back, 1 word/cycle at zero wait). Otherwise go to S_REQ_OFF with mem_req=0.
    - ack with redirect same cycle: data discarded; pc<=redirect_pc; stay in S_REQ with mem_addr=redirect_pc.
    - redirect without ack: latch target into pc; go to S_DROP; mem_req and mem_addr unchanged.
  - S_DROP: request outstanding, result to be discarded.
    - ack: discard; go to S_REQ with mem_addr=pc (the latched target).
    - A further redirect overwrites the target; stay in S_DROP.
    - Redirect and ack together: discard, go to S_REQ using the newest target.
- Space rule: a new request is issued only if count + push - pop < FQ_DEPTH evaluated for the current edge, so the queue never overflows. There is never more than one request outstanding.
- Queue:
  - FIFO with head/tail pointers wrapping modulo FQ_DEPTH; count is 0..FQ_DEPTH.
  - Simultaneous push and pop when full is legal: count stays constant.
  - Pop when empty is ignored.
  - fq_instr and fq_pc reflect the head combinationally from registers; they are 0 when empty.
- Redirect effects:
  - Redirect clears the queue on the same edge, taking priority over push and pop.
  - fq_valid=0 in the cycle after a redirect.
  - In any state, a redirect means no pre-redirect instruction ever reaches fq_*.
- Latency: ack at edge N -> fq_valid=1 after edge N (visible in cycle N+1) if the queue was empty.
- PC arithmetic is 32-bit, wrapping modulo 2^32 (0xFFFF_FFFC+4 -> 0).

Decomposition:
- constants.vh:
  - `_INST_FETCH_RESET_PC (= `_INST_CACHE_OFFSET).
  - `_FQ_DEPTH.
  - State encodings S_REQ_OFF=2'd0, S_REQ=2'd1, S_DROP=2'd2.
  - `_MEM_OP_READ=1'b0.
- One sub-module: fetch_queue.
  - Parameterized FIFO of 64-bit {pc, instr} entries, with push, pop, flush, full, empty and count.
  - inst_fetch holds the FSM, the PC and the space rule.

Test Plan:
- Reset then zero-wait ack (mem_ack=1 always, fq_ready=1, RESET_PC=0):
  - mem_addr sequence 0x0, 0x4, 0x8.
  - fq_pc follows one cycle behind, with fq_instr = mem_rdata for each address.
- Backpressure (fq_ready=0, FQ_DEPTH=4):
  - Exactly 4 acks accepted, then mem_req=0.
  - Raise fq_ready for 1 cycle -> one pop, and exactly one new request at 0x10.
- Wait states: mem_ack low for 3 cycles -> mem_addr is held stable across all 3 cycles; data is accepted only on the ack cycle.
- Redirect without ack (request at 0x8 pending, redirect_pc=0x100):
  - mem_addr remains 0x8 until ack; that data is dropped.
  - The next request is 0x100; the queue is empty afterwards.
- Redirect coincident with ack at 0x8 (redirect_pc=0x203):
  - 0x8 data dropped; next mem_addr=0x200.
  - Queue flushed in the same cycle as a pop.
- Async reset mid-wait:
  - rst low between edges -> mem_req=0, fq_valid=0 immediately.
  - After release, fetch restarts at RESET_PC.
